// File: rtl/ascon_sequencer.sv
// ascon_sequencer: drives the ascon core through one authenticated-encryption run from a host block stream.
// Optional watchdog with sticky error_o is enabled by defining ASCON_SEQ_TIMEOUT_EN.
module ascon_sequencer #(
   parameter int CNT_W = 5
`ifdef ASCON_SEQ_TIMEOUT_EN
   , parameter int TIMEOUT_CYCLES = 1024
`endif
) (
   input  logic               clock_i,
   input  logic               reset_i,
   input  logic               start_i,
   input  logic [CNT_W-1:0]   nb_ad_i,
   input  logic [CNT_W-1:0]   nb_pt_i,
   input  logic [63:0]        blk_data_i,
   input  logic               blk_valid_i,
   output logic               blk_ready_o,
   output logic               init_o,
   output logic               associate_data_o,
   output logic               finalisation_o,
   output logic [63:0]        data_o,
   output logic               data_valid_o,
   input  logic               end_initialisation_i,
   input  logic               end_associate_i,
   input  logic [63:0]        cipher_i,
   input  logic               cipher_valid_i,
   input  logic               end_tag_i,
   input  logic [127:0]       tag_i,
   output logic [63:0]        cipher_o,
   output logic               cipher_valid_o,
   output logic [127:0]       tag_o,
   output logic               busy_o,
`ifdef ASCON_SEQ_TIMEOUT_EN
   output logic               error_o,
`endif
   output logic               done_o
);

   typedef enum logic [3:0] {
      S_IDLE,
      S_WAIT_INIT,
      S_AD_REQ,
      S_AD_WAIT,
      S_PT_REQ,
      S_PT_WAIT,
      S_TAG_WAIT,
      S_DONE,
      S_ERROR
   } state_t;

   state_t             r_state;
   state_t             w_state_next;

   logic [CNT_W-1:0]   r_ad_cnt;
   logic [CNT_W-1:0]   r_pt_cnt;
   logic               r_blk_ready;
   logic               r_init;
   logic               r_assoc;
   logic               r_fin;
   logic [63:0]        r_data;
   logic               r_data_valid;
   logic [63:0]        r_cipher;
   logic               r_cipher_valid;
   logic [127:0]       r_tag;
   logic               r_busy;
   logic               r_done;

   logic               w_start;
   logic               w_accept;
   logic               w_ad_dec;
   logic               w_pt_dec;
   logic               w_cipher_cap;
   logic               w_tag_cap;
   logic               w_timeout;

`ifdef ASCON_SEQ_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [WD_W-1:0]    r_wdog;
   logic               r_error;
   logic               w_in_wait;

   assign w_in_wait = (r_state == S_WAIT_INIT) || (r_state == S_AD_WAIT) ||
                      (r_state == S_PT_WAIT)   || (r_state == S_TAG_WAIT);
   assign w_timeout = w_in_wait && (r_wdog == WD_W'(TIMEOUT_CYCLES - 1));

   // The watchdog only measures time spent in one wait state; any transition restarts it.
   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         r_wdog  <= '0;
         r_error <= 1'b0;
      end else begin
         if (w_state_next != r_state)
            r_wdog <= '0;
         else if (w_in_wait)
            r_wdog <= r_wdog + 1'b1;

         if (w_start)
            r_error <= 1'b0;
         else if (w_state_next == S_ERROR)
            r_error <= 1'b1;
      end
   end

   assign error_o = r_error;
`else
   assign w_timeout = 1'b0;
`endif

   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i)
         r_state <= S_IDLE;
      else
         r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      w_start      = 1'b0;
      w_accept     = 1'b0;
      w_ad_dec     = 1'b0;
      w_pt_dec     = 1'b0;
      w_cipher_cap = 1'b0;
      w_tag_cap    = 1'b0;
      case (r_state)
         S_IDLE, S_ERROR: begin
            if (start_i && (nb_pt_i != '0)) begin
               w_start      = 1'b1;
               w_state_next = S_WAIT_INIT;
            end
         end
         S_WAIT_INIT: begin
            if (end_initialisation_i)
               w_state_next = (r_ad_cnt != '0) ? S_AD_REQ : S_PT_REQ;
         end
         S_AD_REQ: begin
            if (blk_valid_i && r_blk_ready) begin
               w_accept     = 1'b1;
               w_state_next = S_AD_WAIT;
            end
         end
         S_AD_WAIT: begin
            if (end_associate_i) begin
               w_ad_dec     = 1'b1;
               w_state_next = (r_ad_cnt > CNT_W'(1)) ? S_AD_REQ : S_PT_REQ;
            end
         end
         S_PT_REQ: begin
            if (blk_valid_i && r_blk_ready) begin
               w_accept     = 1'b1;
               w_state_next = S_PT_WAIT;
            end
         end
         S_PT_WAIT: begin
            if (cipher_valid_i) begin
               w_cipher_cap = 1'b1;
               w_pt_dec     = 1'b1;
               if (r_pt_cnt > CNT_W'(1)) begin
                  w_state_next = S_PT_REQ;
               end else if (end_tag_i) begin
                  w_tag_cap    = 1'b1;
                  w_state_next = S_DONE;
               end else begin
                  w_state_next = S_TAG_WAIT;
               end
            end
         end
         S_TAG_WAIT: begin
            if (end_tag_i) begin
               w_tag_cap    = 1'b1;
               w_state_next = S_DONE;
            end
         end
         S_DONE: w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
      // A timeout only wins when the awaited core response did not arrive this cycle.
      if (w_timeout && (w_state_next == r_state))
         w_state_next = S_ERROR;
   end

   // Every output is a register whose next value is derived from the upcoming state.
   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         r_ad_cnt       <= '0;
         r_pt_cnt       <= '0;
         r_blk_ready    <= 1'b0;
         r_init         <= 1'b0;
         r_assoc        <= 1'b0;
         r_fin          <= 1'b0;
         r_data         <= '0;
         r_data_valid   <= 1'b0;
         r_cipher       <= '0;
         r_cipher_valid <= 1'b0;
         r_tag          <= '0;
         r_busy         <= 1'b0;
         r_done         <= 1'b0;
      end else begin
         r_init         <= w_start;
         r_blk_ready    <= (w_state_next == S_AD_REQ) || (w_state_next == S_PT_REQ);
         r_busy         <= (w_state_next != S_IDLE) && (w_state_next != S_ERROR);
         r_done         <= (w_state_next == S_DONE);
         r_data_valid   <= w_accept;
         r_assoc        <= w_accept && (r_state == S_AD_REQ);
         r_fin          <= w_accept && (r_state == S_PT_REQ) && (r_pt_cnt == CNT_W'(1));
         r_cipher_valid <= w_cipher_cap;

         if (w_start) begin
            r_ad_cnt <= nb_ad_i;
            r_pt_cnt <= nb_pt_i;
            r_tag    <= '0;
         end else begin
            if (w_ad_dec)
               r_ad_cnt <= r_ad_cnt - 1'b1;
            if (w_pt_dec)
               r_pt_cnt <= r_pt_cnt - 1'b1;
            if (w_tag_cap)
               r_tag <= tag_i;
         end

         if (w_accept)
            r_data <= blk_data_i;
         if (w_cipher_cap)
            r_cipher <= cipher_i;
      end
   end

   assign blk_ready_o      = r_blk_ready;
   assign init_o           = r_init;
   assign associate_data_o = r_assoc;
   assign finalisation_o   = r_fin;
   assign data_o           = r_data;
   assign data_valid_o     = r_data_valid;
   assign cipher_o         = r_cipher;
   assign cipher_valid_o   = r_cipher_valid;
   assign tag_o            = r_tag;
   assign busy_o           = r_busy;
   assign done_o           = r_done;

endmodule

// File: tb/tb_ascon_sequencer.sv
// tb_ascon_sequencer: scoreboard bench with a simple core stand-in (cipher = block ^ mask, fixed tag per run).
// Define ASCON_SEQ_TIMEOUT_EN to also exercise the watchdog.
module tb_ascon_sequencer;

   localparam int          CNT_W       = 5;
   localparam logic [63:0] CIPHER_MASK = 64'hA5A5_5A5A_0F0F_F0F0;

   typedef enum int {EV_INIT, EV_DATA, EV_CIPHER, EV_DONE} evKind_t;

   typedef struct {
      evKind_t      kind;
      logic [63:0]  data;
      logic         assoc;
      logic         fin;
      logic [127:0] tag;
   } expEvent_t;

   expEvent_t sbQ[$];
   int checkCount = 0;
   int errorCount = 0;
   int runId      = 0;

   logic             clock = 1'b0;
   logic             resetN = 1'b0;
   logic             startIn = 1'b0;
   logic [CNT_W-1:0] nbAdIn = '0;
   logic [CNT_W-1:0] nbPtIn = '0;
   logic [63:0]      blkData = '0;
   logic             blkValid = 1'b0;
   logic             endInit = 1'b0;
   logic             endAssoc = 1'b0;
   logic [63:0]      cipherIn = '0;
   logic             cipherValid = 1'b0;
   logic             endTag = 1'b0;
   logic [127:0]     tagIn = '0;
   logic [127:0]     curTag = '0;
   logic             simulTagMode = 1'b0;
   logic             coreNoInit = 1'b0;

   logic             blk_ready_o, init_o, associate_data_o, finalisation_o, data_valid_o;
   logic [63:0]      data_o, cipher_o;
   logic             cipher_valid_o, busy_o, done_o;
   logic [127:0]     tag_o;
`ifdef ASCON_SEQ_TIMEOUT_EN
   logic             errorOut;
`endif

   ascon_sequencer #(.CNT_W(CNT_W)) dut (
      .clock_i              (clock),
      .reset_i              (resetN),
      .start_i              (startIn),
      .nb_ad_i              (nbAdIn),
      .nb_pt_i              (nbPtIn),
      .blk_data_i           (blkData),
      .blk_valid_i          (blkValid),
      .blk_ready_o          (blk_ready_o),
      .init_o               (init_o),
      .associate_data_o     (associate_data_o),
      .finalisation_o       (finalisation_o),
      .data_o               (data_o),
      .data_valid_o         (data_valid_o),
      .end_initialisation_i (endInit),
      .end_associate_i      (endAssoc),
      .cipher_i             (cipherIn),
      .cipher_valid_i       (cipherValid),
      .end_tag_i            (endTag),
      .tag_i                (tagIn),
      .cipher_o             (cipher_o),
      .cipher_valid_o       (cipher_valid_o),
      .tag_o                (tag_o),
      .busy_o               (busy_o),
`ifdef ASCON_SEQ_TIMEOUT_EN
      .error_o              (errorOut),
`endif
      .done_o               (done_o)
   );

   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("[TB] FAIL global_timeout: simulation still running at %0t, required finish earlier", $time);
      $fatal(1, "[TB] global timeout");
   end

   task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   function automatic logic [63:0] adWord(input int idx);
      return {16'hAD00, 16'(runId), 32'(idx)};
   endfunction

   function automatic logic [63:0] ptWord(input int idx);
      return {16'h5A00, 16'(runId), 32'(idx * 3 + 1)};
   endfunction

   task automatic pushExp(input evKind_t kind, input logic [63:0] data, input logic assoc,
                          input logic fin, input logic [127:0] tag);
      expEvent_t e;
      e.kind  = kind;
      e.data  = data;
      e.assoc = assoc;
      e.fin   = fin;
      e.tag   = tag;
      sbQ.push_back(e);
   endtask

   task automatic checkEvent(input evKind_t kind);
      expEvent_t e;
      if (sbQ.size() == 0) begin
         checkCount++;
         errorCount++;
         $display("[TB] FAIL unexpected_event: got kind %0d, expected no event", kind);
         return;
      end
      e = sbQ.pop_front();
      checkOutput("event_kind", 128'(kind), 128'(e.kind));
      case (e.kind)
         EV_INIT:   checkOutput("init_busy", 128'(busy_o), 128'(1));
         EV_DATA: begin
            checkOutput("data_o", 128'(data_o), 128'(e.data));
            checkOutput("associate_data_o", 128'(associate_data_o), 128'(e.assoc));
            checkOutput("finalisation_o", 128'(finalisation_o), 128'(e.fin));
         end
         EV_CIPHER: checkOutput("cipher_o", 128'(cipher_o), 128'(e.data));
         EV_DONE: begin
            checkOutput("tag_o_at_done", tag_o, e.tag);
            if (e.fin)
               checkOutput("done_with_last_cipher", 128'(cipher_valid_o), 128'(1));
         end
         default: ;
      endcase
   endtask

   // Monitor: every output strobe pops the scoreboard in a fixed per-cycle order.
   always @(negedge clock) begin
      if (resetN) begin
         if (init_o)         checkEvent(EV_INIT);
         if (data_valid_o)   checkEvent(EV_DATA);
         if (cipher_valid_o) checkEvent(EV_CIPHER);
         if (done_o)         checkEvent(EV_DONE);
      end
   end

   // Core stand-in: answers each strobe a few cycles later, driving on falling edges.
   initial begin : coreModel
      logic [63:0] blk;
      logic        isFin;
      forever begin
         @(negedge clock);
         if (resetN && init_o && !coreNoInit) begin
            repeat (2) @(negedge clock);
            endInit = 1'b1;
            @(negedge clock);
            endInit = 1'b0;
         end else if (resetN && data_valid_o && associate_data_o) begin
            @(negedge clock);
            endAssoc = 1'b1;
            @(negedge clock);
            endAssoc = 1'b0;
         end else if (resetN && data_valid_o) begin
            blk   = data_o;
            isFin = finalisation_o;
            repeat (2) @(negedge clock);
            cipherIn    = blk ^ CIPHER_MASK;
            cipherValid = 1'b1;
            if (isFin && simulTagMode) begin
               tagIn  = curTag;
               endTag = 1'b1;
            end
            @(negedge clock);
            cipherValid = 1'b0;
            endTag      = 1'b0;
            if (isFin && !simulTagMode) begin
               @(negedge clock);
               tagIn  = curTag;
               endTag = 1'b1;
               @(negedge clock);
               endTag = 1'b0;
            end
         end
      end
   end

   task automatic sendBlock(input logic [63:0] d);
      int waitCnt;
      blkValid = 1'b1;
      blkData  = d;
      waitCnt  = 0;
      while (!blk_ready_o && waitCnt < 200) begin
         @(negedge clock);
         waitCnt++;
      end
      checkOutput("blk_accepted", 128'(waitCnt < 200), 128'(1));
      @(negedge clock);
      blkValid = 1'b0;
   endtask

   task automatic applyStimulus(input int nbAd, input int nbPt, input bit simulTag,
                                input bit stallPt, input bit pokeStart);
      int waitCnt;
      int stallOk;
      runId++;
      curTag       = {48'hC0FFEE_5EC000, 16'(runId), 64'h0123_4567_89AB_CDEF};
      simulTagMode = simulTag;
      pushExp(EV_INIT, '0, 1'b0, 1'b0, '0);
      for (int i = 0; i < nbAd; i++)
         pushExp(EV_DATA, adWord(i), 1'b1, 1'b0, '0);
      for (int i = 0; i < nbPt; i++) begin
         pushExp(EV_DATA, ptWord(i), 1'b0, (i == nbPt - 1), '0);
         pushExp(EV_CIPHER, ptWord(i) ^ CIPHER_MASK, 1'b0, 1'b0, '0);
      end
      pushExp(EV_DONE, '0, 1'b0, simulTag, curTag);

      @(negedge clock);
      startIn = 1'b1;
      nbAdIn  = CNT_W'(nbAd);
      nbPtIn  = CNT_W'(nbPt);
      @(negedge clock);
      startIn = 1'b0;
      if (pokeStart) begin
         startIn = 1'b1;
         nbAdIn  = 5'd3;
         nbPtIn  = 5'd7;
         @(negedge clock);
         startIn = 1'b0;
      end

      for (int i = 0; i < nbAd; i++)
         sendBlock(adWord(i));
      for (int i = 0; i < nbPt; i++) begin
         if (stallPt && i == 0) begin
            waitCnt = 0;
            while (!blk_ready_o && waitCnt < 200) begin
               @(negedge clock);
               waitCnt++;
            end
            stallOk = 0;
            repeat (50) begin
               @(negedge clock);
               if (blk_ready_o && !data_valid_o)
                  stallOk++;
            end
            checkOutput("stall_ready_held", 128'(stallOk), 128'(50));
         end
         sendBlock(ptWord(i));
      end

      waitCnt = 0;
      while (!done_o && waitCnt < 300) begin
         @(negedge clock);
         waitCnt++;
      end
      checkOutput("run_done_seen", 128'(done_o), 128'(1));
      @(negedge clock);
      checkOutput("busy_after_done", 128'(busy_o), 128'(0));
      checkOutput("tag_held_after_done", tag_o, curTag);
   endtask

   task automatic checkAllZero(input string name);
      checkOutput(name, 128'({blk_ready_o, init_o, associate_data_o, finalisation_o,
                              data_valid_o, cipher_valid_o, busy_o, done_o}), 128'(0));
      checkOutput({name, "_data"}, 128'(data_o), 128'(0));
      checkOutput({name, "_cipher"}, 128'(cipher_o), 128'(0));
      checkOutput({name, "_tag"}, tag_o, 128'(0));
   endtask

   initial begin
      int waitCnt;
      repeat (3) @(negedge clock);
      checkAllZero("reset_outputs");
      resetN = 1'b1;
      repeat (2) @(negedge clock);
      checkOutput("idle_not_busy", 128'(busy_o), 128'(0));

      $display("[TB] run: nb_ad=1 nb_pt=23");
      applyStimulus(1, 23, 1'b0, 1'b0, 1'b0);

      $display("[TB] run: nb_ad=0 nb_pt=1 with start pulsed while busy");
      applyStimulus(0, 1, 1'b0, 1'b0, 1'b1);

      $display("[TB] start with nb_pt=0");
      @(negedge clock);
      startIn = 1'b1;
      nbAdIn  = 5'd2;
      nbPtIn  = 5'd0;
      @(negedge clock);
      startIn = 1'b0;
      repeat (5) @(negedge clock);
      checkOutput("nbpt0_ignored_busy", 128'(busy_o), 128'(0));

      $display("[TB] run: host stalls 50 cycles in PT_REQ");
      applyStimulus(1, 2, 1'b0, 1'b1, 1'b0);

      $display("[TB] run: last cipher and tag together");
      applyStimulus(0, 3, 1'b1, 1'b0, 1'b0);

      $display("[TB] reset during AD phase, then nb_ad=2 nb_pt=3");
      runId++;
      curTag = '0;
      pushExp(EV_INIT, '0, 1'b0, 1'b0, '0);
      pushExp(EV_DATA, adWord(0), 1'b1, 1'b0, '0);
      @(negedge clock);
      startIn = 1'b1;
      nbAdIn  = 5'd3;
      nbPtIn  = 5'd2;
      @(negedge clock);
      startIn = 1'b0;
      sendBlock(adWord(0));
      waitCnt = 0;
      while (!blk_ready_o && waitCnt < 200) begin
         @(negedge clock);
         waitCnt++;
      end
      checkOutput("abort_second_ad_ready", 128'(blk_ready_o), 128'(1));
      checkOutput("abort_scoreboard_drained", 128'(sbQ.size()), 128'(0));
      resetN = 1'b0;
      repeat (2) @(negedge clock);
      checkAllZero("midrun_reset_outputs");
      resetN = 1'b1;
      @(negedge clock);
      applyStimulus(2, 3, 1'b0, 1'b0, 1'b0);

`ifdef ASCON_SEQ_TIMEOUT_EN
      $display("[TB] watchdog: core never ends initialisation");
      coreNoInit = 1'b1;
      pushExp(EV_INIT, '0, 1'b0, 1'b0, '0);
      @(negedge clock);
      startIn = 1'b1;
      nbAdIn  = 5'd0;
      nbPtIn  = 5'd1;
      @(negedge clock);
      startIn = 1'b0;
      waitCnt = 1;
      while (!errorOut && waitCnt < 2000) begin
         @(negedge clock);
         waitCnt++;
      end
      checkOutput("timeout_cycles", 128'(waitCnt), 128'(1025));
      checkOutput("timeout_not_busy", 128'(busy_o), 128'(0));
      coreNoInit = 1'b0;
      applyStimulus(0, 1, 1'b0, 1'b0, 1'b0);
      checkOutput("error_cleared_by_start", 128'(errorOut), 128'(0));
`endif

      repeat (5) @(negedge clock);
      checkOutput("scoreboard_empty", 128'(sbQ.size()), 128'(0));
      checkOutput("tag_still_held", tag_o, curTag);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule

// File: doc/ascon_sequencer.md
Name: ascon_sequencer

Overview:
- Hardware initiator that drives the ascon core's control and data interface through one complete authenticated-encryption run.
- Accepts 64-bit associated-data (AD) and plaintext (PT) blocks from an upstream host over a valid/ready stream.
- Issues the init, AD, data and finalisation strobes to the core, then returns cipher blocks and the 128-bit tag.
- Sits between the ECG sample packer and the ascon core and replaces testbench-only sequencing.

Parameters:
CNT_W, 5, width of block-count inputs and internal block counters (max 2^CNT_W-1 blocks per phase)
TIMEOUT_CYCLES, 1024, watchdog limit in clock cycles (used only with the optional feature)

Ports:
clock_i  in  1  system clock, rising edge
reset_i  in  1  asynchronous active-low reset
start_i  in  1  start a run; sampled in IDLE only
nb_ad_i  in  CNT_W  number of AD blocks, 0 allowed; latched at start
nb_pt_i  in  CNT_W  number of PT blocks, must be >=1; latched at start
blk_data_i  in  64  host block: AD blocks first, then PT blocks
blk_valid_i  in  1  host block valid
blk_ready_o  out  1  sequencer accepts blk_data_i this cycle
init_o  out  1  to core: start initialisation, 1-cycle pulse
associate_data_o  out  1  to core: current data_valid_o carries an AD block
finalisation_o  out  1  to core: current data_valid_o carries the last PT block
data_o  out  64  to core: block data, registered
data_valid_o  out  1  to core: 1-cycle block strobe
end_initialisation_i  in  1  from core: initialisation done
end_associate_i  in  1  from core: AD block absorbed
cipher_i  in  64  from core: cipher block
cipher_valid_i  in  1  from core: cipher_i valid
end_tag_i  in  1  from core: tag valid
tag_i  in  128  from core: tag
cipher_o  out  64  cipher block to host
cipher_valid_o  out  1  1-cycle strobe; no backpressure
tag_o  out  128  captured tag, held until next start
busy_o  out  1  high from start acceptance to DONE
done_o  out  1  1-cycle pulse at end of run

Behaviour:
- Reset: IDLE; all outputs 0; counters 0; tag_o 0.
- All outputs are registered.
- IDLE: on start_i=1 with nb_pt_i!=0, latch counts, set busy_o, pulse init_o on the next cycle, go to WAIT_INIT. start_i with nb_pt_i=0 is ignored.
- WAIT_INIT: on end_initialisation_i go to AD_REQ if ad_cnt>0, else PT_REQ.
- AD_REQ: blk_ready_o=1. On blk_valid_i&&blk_ready_o, register the data, then the next cycle pulse data_valid_o with associate_data_o=1 and go to AD_WAIT. blk_ready_o drops in the same cycle as the handshake.
- AD_WAIT: on end_associate_i decrement ad_cnt, then go to AD_REQ if ad_cnt>0, else PT_REQ.
- PT_REQ: same handshake as AD_REQ, with associate_data_o=0. finalisation_o=1 with the strobe when pt_cnt==1. Go to PT_WAIT.
- PT_WAIT: on cipher_valid_i copy cipher_i to cipher_o and pulse cipher_valid_o the next cycle, then decrement pt_cnt.
  - If the decremented count >0, go to PT_REQ.
  - Otherwise go to TAG_WAIT.
  - If end_tag_i arrives in the same cycle as the final cipher_valid_i, capture both and go straight to DONE.
- TAG_WAIT: on end_tag_i capture tag_i into tag_o and go to DONE.
- DONE: pulse done_o for 1 cycle, clear busy_o, go to IDLE.
- Core responses arriving in any state other than the one waiting for them are ignored.
- start_i while busy_o=1 is ignored.
- Host data is not consumed outside the REQ states.
- Reset mid-run aborts immediately to IDLE. The core receives no further strobes; the core itself must also be reset.
- Minimum latency from strobe to next blk_ready_o: 1 cycle after the core response.

Optional Feature:
ASCON_SEQ_TIMEOUT_EN
- Defined: a watchdog counter clears on every state change and counts while in WAIT_INIT, AD_WAIT, PT_WAIT or TAG_WAIT.
  - At TIMEOUT_CYCLES the FSM enters ERROR and raises an extra output error_o (1 bit, sticky).
  - ERROR leaves only by reset or start_i (which clears error_o and starts a new run). done_o is not pulsed.
- Not defined: no counter, no error_o port; waits are unbounded.

Test Plan:
- Key 8A55114D1CB6A9A2BE263D4D7AECAAFF, nonce 4ED0EC0B98C529B7C8CDDF37BCD0284A, nb_ad=1, nb_pt=23, against the ascon core -> exactly 1 init_o, 1 AD strobe, 23 PT strobes with finalisation_o only on the 23rd, 23 cipher_valid_o, tag_o equals the golden reference model, done_o once.
- nb_ad=0, nb_pt=1 -> no associate_data_o ever; the first and only PT strobe has finalisation_o=1; the tag is captured.
- Host withholds blk_valid_i for 50 cycles in PT_REQ -> blk_ready_o stays 1, no strobe to the core, state holds.
- Core model asserts the last cipher_valid_i and end_tag_i in the same cycle -> both are captured, done_o follows next cycle.
- reset_i low mid-way through the AD phase, then start nb_ad=2, nb_pt=3 -> all outputs 0 during reset; the new run completes normally.
- start_i with nb_pt=0, then start_i during busy -> both ignored.
- With ASCON_SEQ_TIMEOUT_EN, the core never returns end_initialisation_i -> error_o=1 after 1024 cycles.
